// File: rtl/cbfp_pkg.sv
// Shared constants and types for the CBFP group sequencer.
package cbfp_pkg;

    localparam int unsigned SHIFT_WIDTH = 5;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_e;

    localparam logic [SHIFT_WIDTH-1:0] SHIFT_INIT = '1;

endpackage

// File: rtl/cbfp_run_min.sv
// Running-minimum register: tracks the smallest shift amount seen within a group.
module cbfp_run_min
    import cbfp_pkg::*;
#(
    parameter int unsigned Width = SHIFT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic             first_i,
    input  logic             clr_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] min_nxt_o
);

    localparam logic [Width-1:0] Init = '1;

    logic [Width-1:0] min_q, min_d;

    // min_nxt_o already includes the current beat so the caller can latch the group result.
    always_comb begin
        if (first_i) begin
            min_nxt_o = din_i;
        end else if (din_i < min_q) begin
            min_nxt_o = din_i;
        end else begin
            min_nxt_o = min_q;
        end
        min_d = min_q;
        if (en_i) begin
            min_d = clr_i ? Init : min_nxt_o;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            min_q <= Init;
        end else begin
            min_q <= min_d;
        end
    end

endmodule

// File: rtl/cbfp_group_ctrl.sv
// CBFP group sequencer: gathers per-group minimum shifts and runs a two-bank
// ping-pong buffer, holding the group shift on the shift unit while a bank drains.
module cbfp_group_ctrl #(
    parameter int unsigned SHIFT_WIDTH  = 5,
    parameter int unsigned GROUP_BEATS  = 8,
    parameter int unsigned FRAME_GROUPS = 4,
    parameter int unsigned ADDR_WIDTH   = $clog2(GROUP_BEATS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [SHIFT_WIDTH-1:0] min_re_in,
    input  logic [SHIFT_WIDTH-1:0] min_im_in,
    output logic                   wr_en,
    output logic                   wr_bank,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic                   dout_ready,
    output logic                   rd_en,
    output logic                   rd_bank,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [SHIFT_WIDTH-1:0] shift_amt_re,
    output logic [SHIFT_WIDTH-1:0] shift_amt_im,
    output logic                   valid_out,
    output logic                   frame_last,
    output logic                   grp_exp_valid,
    output logic                   overflow_err
);

    import cbfp_pkg::*;

    localparam int unsigned GrpWidth = (FRAME_GROUPS > 1) ? $clog2(FRAME_GROUPS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(GROUP_BEATS - 1);
    localparam logic [GrpWidth-1:0] LastGrp = GrpWidth'(FRAME_GROUPS - 1);

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic [SHIFT_WIDTH-1:0] bank_re_q [2];
    logic [SHIFT_WIDTH-1:0] bank_re_d [2];
    logic [SHIFT_WIDTH-1:0] bank_im_q [2];
    logic [SHIFT_WIDTH-1:0] bank_im_d [2];

    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [GrpWidth-1:0]    grp_cnt_q, grp_cnt_d;
    logic [SHIFT_WIDTH-1:0] shift_re_q, shift_re_d;
    logic [SHIFT_WIDTH-1:0] shift_im_q, shift_im_d;
    logic                   valid_out_q, valid_out_d;
    logic                   frame_last_q, frame_last_d;
    logic                   grp_exp_valid_q, grp_exp_valid_d;
    logic                   overflow_q, overflow_d;

    logic                   wr_go, wr_last, rd_go, rd_last, wr_first;
    logic [SHIFT_WIDTH-1:0] run_re_nxt, run_im_nxt;

    always_comb begin
        din_ready = (bank_q[wr_bank_q] == EMPTY) || (bank_q[wr_bank_q] == FILLING);
        wr_go     = din_valid && din_ready;
        wr_first  = (wr_addr_q == '0);
        wr_last   = wr_go && (wr_addr_q == LastAddr);
        rd_go     = dout_ready && ((bank_q[rd_bank_q] == FULL) || (bank_q[rd_bank_q] == DRAINING));
        rd_last   = rd_go && (rd_addr_q == LastAddr);
    end

    cbfp_run_min #(
        .Width (SHIFT_WIDTH)
    ) u_run_min_re (
        .clk       (clk),
        .rstn      (rstn),
        .en_i      (wr_go),
        .first_i   (wr_first),
        .clr_i     (wr_last),
        .din_i     (min_re_in),
        .min_nxt_o (run_re_nxt)
    );

    cbfp_run_min #(
        .Width (SHIFT_WIDTH)
    ) u_run_min_im (
        .clk       (clk),
        .rstn      (rstn),
        .en_i      (wr_go),
        .first_i   (wr_first),
        .clr_i     (wr_last),
        .din_i     (min_im_in),
        .min_nxt_o (run_im_nxt)
    );

    // Write and read sides always address different banks, so both updates apply.
    always_comb begin
        bank_d          = bank_q;
        bank_re_d       = bank_re_q;
        bank_im_d       = bank_im_q;
        wr_bank_d       = wr_bank_q;
        rd_bank_d       = rd_bank_q;
        wr_addr_d       = wr_addr_q;
        rd_addr_d       = rd_addr_q;
        grp_cnt_d       = grp_cnt_q;
        shift_re_d      = shift_re_q;
        shift_im_d      = shift_im_q;
        valid_out_d     = rd_go;
        frame_last_d    = rd_last && (grp_cnt_q == LastGrp);
        grp_exp_valid_d = wr_last;
        overflow_d      = overflow_q || (din_valid && !din_ready);

        if (wr_go) begin
            bank_d[wr_bank_q] = FILLING;
            wr_addr_d         = wr_addr_q + ADDR_WIDTH'(1);
            if (wr_last) begin
                bank_d[wr_bank_q]    = FULL;
                bank_re_d[wr_bank_q] = run_re_nxt;
                bank_im_d[wr_bank_q] = run_im_nxt;
                wr_bank_d            = ~wr_bank_q;
                wr_addr_d            = '0;
            end
        end

        if (rd_go) begin
            bank_d[rd_bank_q] = DRAINING;
            rd_addr_d         = rd_addr_q + ADDR_WIDTH'(1);
            // Registered so the shift lines up with buffer read data (valid_out).
            shift_re_d        = bank_re_q[rd_bank_q];
            shift_im_d        = bank_im_q[rd_bank_q];
            if (rd_last) begin
                bank_d[rd_bank_q] = EMPTY;
                rd_bank_d         = ~rd_bank_q;
                rd_addr_d         = '0;
                grp_cnt_d         = (grp_cnt_q == LastGrp) ? '0 : grp_cnt_q + GrpWidth'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b]    <= EMPTY;
                bank_re_q[b] <= '1;
                bank_im_q[b] <= '1;
            end
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            wr_addr_q       <= '0;
            rd_addr_q       <= '0;
            grp_cnt_q       <= '0;
            shift_re_q      <= '0;
            shift_im_q      <= '0;
            valid_out_q     <= 1'b0;
            frame_last_q    <= 1'b0;
            grp_exp_valid_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            bank_q          <= bank_d;
            bank_re_q       <= bank_re_d;
            bank_im_q       <= bank_im_d;
            wr_bank_q       <= wr_bank_d;
            rd_bank_q       <= rd_bank_d;
            wr_addr_q       <= wr_addr_d;
            rd_addr_q       <= rd_addr_d;
            grp_cnt_q       <= grp_cnt_d;
            shift_re_q      <= shift_re_d;
            shift_im_q      <= shift_im_d;
            valid_out_q     <= valid_out_d;
            frame_last_q    <= frame_last_d;
            grp_exp_valid_q <= grp_exp_valid_d;
            overflow_q      <= overflow_d;
        end
    end

    always_comb begin
        wr_en         = wr_go;
        wr_bank       = wr_bank_q;
        wr_addr       = wr_addr_q;
        rd_en         = rd_go;
        rd_bank       = rd_bank_q;
        rd_addr       = rd_addr_q;
        shift_amt_re  = shift_re_q;
        shift_amt_im  = shift_im_q;
        valid_out     = valid_out_q;
        frame_last    = frame_last_q;
        grp_exp_valid = grp_exp_valid_q;
        overflow_err  = overflow_q;
    end

endmodule

// File: tb/tb_cbfp_group_ctrl.sv
// Directed bench for cbfp_group_ctrl: cycle table for streaming, plus hand sequences.
module tb_cbfp_group_ctrl;

    localparam int SW = 5;
    localparam int GB = 8;
    localparam int FG = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          din_valid;
    logic          din_ready;
    logic [SW-1:0] min_re_in;
    logic [SW-1:0] min_im_in;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          dout_ready;
    logic          rd_en;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] shift_amt_re;
    logic [SW-1:0] shift_amt_im;
    logic          valid_out;
    logic          frame_last;
    logic          grp_exp_valid;
    logic          overflow_err;

    always #5 clk = ~clk;

    cbfp_group_ctrl #(
        .SHIFT_WIDTH  (SW),
        .GROUP_BEATS  (GB),
        .FRAME_GROUPS (FG),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .min_re_in     (min_re_in),
        .min_im_in     (min_im_in),
        .wr_en         (wr_en),
        .wr_bank       (wr_bank),
        .wr_addr       (wr_addr),
        .dout_ready    (dout_ready),
        .rd_en         (rd_en),
        .rd_bank       (rd_bank),
        .rd_addr       (rd_addr),
        .shift_amt_re  (shift_amt_re),
        .shift_amt_im  (shift_amt_im),
        .valid_out     (valid_out),
        .frame_last    (frame_last),
        .grp_exp_valid (grp_exp_valid),
        .overflow_err  (overflow_err)
    );

    typedef struct {
        logic          dv;
        logic [SW-1:0] re;
        logic [SW-1:0] im;
        logic          dr;
        logic          rdy;
        logic          wen;
        logic          ren;
        logic          vo;
        logic          gev;
        logic          cs;
        logic [SW-1:0] sre;
        logic [SW-1:0] sim;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic          s_rdy, s_wen, s_ren, s_vo, s_fl, s_gev, s_ovf, s_wrb, s_rdb;
    logic [SW-1:0] s_sre, s_sim;
    logic [AW-1:0] s_wra, s_rda;

    int q_re[$];
    int q_im[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs are driven at the falling edge; all outputs are sampled 1 time unit later.
    task automatic cyc(input logic dv, input int re, input int im, input logic dr);
        din_valid  = dv;
        min_re_in  = SW'(re);
        min_im_in  = SW'(im);
        dout_ready = dr;
        #1;
        s_rdy = din_ready;  s_wen = wr_en;     s_ren = rd_en;  s_vo = valid_out;
        s_fl  = frame_last; s_gev = grp_exp_valid; s_ovf = overflow_err;
        s_wrb = wr_bank;    s_rdb = rd_bank;   s_wra = wr_addr; s_rda = rd_addr;
        s_sre = shift_amt_re; s_sim = shift_amt_im;
        if (s_vo) begin
            q_re.push_back(int'(s_sre));
            q_im.push_back(int'(s_sim));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; din_valid = 1'b0; min_re_in = '0; min_im_in = '0; dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        q_re.delete();
        q_im.delete();
    endtask

    task automatic add(input int dv, input int re, input int im, input int dr, input int rdy,
                       input int wen, input int ren, input int vo, input int gev, input int cs,
                       input int sre, input int sim);
        vec_t v;
        v.dv = dv[0]; v.re = SW'(re); v.im = SW'(im); v.dr = dr[0];
        v.rdy = rdy[0]; v.wen = wen[0]; v.ren = ren[0]; v.vo = vo[0]; v.gev = gev[0];
        v.cs = cs[0]; v.sre = SW'(sre); v.sim = SW'(sim);
        vecs.push_back(v);
    endtask

    task automatic chk_groups(input string tag, input int n, input int re0, input int im0,
                              input int re1, input int im1);
        chk({tag, "_beats"}, q_re.size(), n);
        for (int i = 0; i < q_re.size() && i < n; i++) begin
            chk($sformatf("%s_re%0d", tag, i), q_re[i], (i < GB) ? re0 : re1);
            chk($sformatf("%s_im%0d", tag, i), q_im[i], (i < GB) ? im0 : im1);
        end
    endtask

    initial begin
        int first_vo, last_vo, n_vo, n_fl, fl_pos0, fl_pos1, n_nrdy, n_ren;

        do_reset();
        cyc(0, 0, 0, 0);
        chk("rst_din_ready", s_rdy, 1);
        chk("rst_wr_en", s_wen, 0);
        chk("rst_rd_en", s_ren, 0);
        chk("rst_valid_out", s_vo, 0);
        chk("rst_frame_last", s_fl, 0);
        chk("rst_grp_exp_valid", s_gev, 0);
        chk("rst_overflow", s_ovf, 0);
        chk("rst_wr_bank", s_wrb, 0);
        chk("rst_rd_bank", s_rdb, 0);
        chk("rst_wr_addr", s_wra, 0);
        chk("rst_rd_addr", s_rda, 0);
        chk("rst_shift_re", s_sre, 0);
        chk("rst_shift_im", s_sim, 0);

        // Streaming: 16 beats re=index+3, im=10; group mins 3 and 11.
        for (int k = 0; k < 8; k++) add(1, k + 3, 10, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 11, 10, 1, 1, 1, 1, 0, 1, 0, 0, 0);
        for (int k = 9; k < 16; k++) add(1, k + 3, 10, 1, 1, 1, 1, 1, 0, 1, 3, 10);
        add(0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 3, 10);
        for (int k = 17; k < 24; k++) add(0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 11, 10);
        add(0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 11, 10);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 11, 10);
        // Minimum arriving on the last beat of the group.
        for (int k = 0; k < 7; k++) add(1, 20, 9, 1, 1, 1, 0, 0, 0, 1, 11, 10);
        add(1, 2, 9, 1, 1, 1, 0, 0, 0, 1, 11, 10);
        add(0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 11, 10);
        for (int k = 0; k < 7; k++) add(0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 2, 9);
        add(0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 2, 9);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 2, 9);

        foreach (vecs[i]) begin
            cyc(vecs[i].dv, int'(vecs[i].re), int'(vecs[i].im), vecs[i].dr);
            chk($sformatf("v%0d_din_ready", i), s_rdy, vecs[i].rdy);
            chk($sformatf("v%0d_wr_en", i), s_wen, vecs[i].wen);
            chk($sformatf("v%0d_rd_en", i), s_ren, vecs[i].ren);
            chk($sformatf("v%0d_valid_out", i), s_vo, vecs[i].vo);
            chk($sformatf("v%0d_grp_exp_valid", i), s_gev, vecs[i].gev);
            chk($sformatf("v%0d_frame_last", i), s_fl, 0);
            if (vecs[i].cs) begin
                chk($sformatf("v%0d_shift_re", i), s_sre, vecs[i].sre);
                chk($sformatf("v%0d_shift_im", i), s_sim, vecs[i].sim);
            end
        end

        // Frame marker: 64 continuous beats, frame_last on valid beats 32 and 64.
        do_reset();
        first_vo = -1; last_vo = -1; n_vo = 0; n_fl = 0; fl_pos0 = -1; fl_pos1 = -1; n_nrdy = 0;
        for (int k = 0; k < 80; k++) begin
            cyc(k < 64, 5, 5, 1);
            if (!s_rdy) n_nrdy++;
            if (s_vo) begin
                n_vo++;
                if (first_vo < 0) first_vo = k;
                last_vo = k;
            end
            if (s_fl) begin
                n_fl++;
                if (fl_pos0 < 0) fl_pos0 = n_vo; else fl_pos1 = n_vo;
            end
        end
        chk("frm_valid_count", n_vo, 64);
        chk("frm_first_valid_cycle", first_vo, 9);
        chk("frm_last_valid_cycle", last_vo, 72);
        chk("frm_last_count", n_fl, 2);
        chk("frm_last_pos0", fl_pos0, 32);
        chk("frm_last_pos1", fl_pos1, 64);
        chk("frm_din_ready_drops", n_nrdy, 0);

        // Backpressure: both banks fill, beats 17..24 are dropped.
        do_reset();
        n_ren = 0;
        for (int k = 0; k < 24; k++) begin
            cyc(1, (k < 8) ? 20 - k : ((k < 16) ? 38 - k : 0), (k < 8) ? 1 : ((k < 16) ? 2 : 0), 0);
            if (s_ren) n_ren++;
            if (k == 15) begin
                chk("bp_ready_b16", s_rdy, 1);
                chk("bp_ovf_b16", s_ovf, 0);
            end
            if (k == 16) begin
                chk("bp_ready_b17", s_rdy, 0);
                chk("bp_wr_en_b17", s_wen, 0);
                chk("bp_ovf_b17", s_ovf, 0);
            end
            if (k == 17) chk("bp_ovf_after", s_ovf, 1);
            if (k == 23) chk("bp_ready_b24", s_rdy, 0);
        end
        chk("bp_no_reads", n_ren, 0);
        for (int k = 0; k < 24; k++) cyc(0, 0, 0, 1);
        chk("bp_ready_drained", s_rdy, 1);
        chk("bp_ovf_sticky", s_ovf, 1);
        chk_groups("bp", 16, 13, 1, 23, 2);

        // Reset mid-group discards the partial group.
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1, 1, 1, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_async_wr_addr", wr_addr, 0);
        chk("mid_rst_async_ovf", overflow_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        cyc(0, 0, 0, 1);
        chk("mid_rst_wr_bank", s_wrb, 0);
        chk("mid_rst_rd_bank", s_rdb, 0);
        chk("mid_rst_wr_addr", s_wra, 0);
        chk("mid_rst_valid", s_vo, 0);
        q_re.delete();
        q_im.delete();
        for (int k = 0; k < 8; k++) cyc(1, 7, 7, 1);
        for (int k = 0; k < 12; k++) cyc(0, 0, 0, 1);
        chk_groups("mid", 8, 7, 7, 7, 7);

        // Bank 1's last write coincides with bank 0's last read.
        do_reset();
        for (int k = 0; k < 8; k++) cyc(1, 15, 15, 1);
        cyc(0, 0, 0, 0);
        for (int k = 9; k < 17; k++) begin
            cyc(1, 4, 6, 1);
            if (k == 16) begin
                chk("sim_k16_rd_en", s_ren, 1);
                chk("sim_k16_wr_en", s_wen, 1);
                chk("sim_k16_rd_addr", s_rda, GB - 1);
                chk("sim_k16_wr_addr", s_wra, GB - 1);
            end
        end
        cyc(0, 0, 0, 1);
        chk("sim_k17_rd_en", s_ren, 1);
        chk("sim_k17_rd_bank", s_rdb, 1);
        chk("sim_k17_wr_bank", s_wrb, 0);
        chk("sim_k17_din_ready", s_rdy, 1);
        for (int k = 18; k < 31; k++) cyc(0, 0, 0, 1);
        chk_groups("sim", 16, 15, 15, 4, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cbfp_group_ctrl.md
Name: cbfp_group_ctrl

Overview:
- Sequencer for the 16-lane CBFP stage.
- Collects per-beat minimum shift amounts from the real/imag min-detect units over a group of GROUP_BEATS beats.
- Drives a two-bank ping-pong sample buffer, writing one group while draining the other.
- During drain, holds the group-wide shift amount on the shift unit, so one block exponent covers the whole group.
- Emits the per-group exponent and frame markers for downstream de-normalisation.

Parameters:
- SHIFT_WIDTH, 5, width of shift amounts (0..31).
- GROUP_BEATS, 8, beats (16 samples each) per CBFP group; power of two, at least 2.
- FRAME_GROUPS, 4, groups per FFT frame (4 x 8 x 16 = 512 points).
- ADDR_WIDTH, $clog2(GROUP_BEATS), buffer beat address width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- din_valid  in  1  input beat present
- din_ready  out  1  write bank can accept a beat
- min_re_in  in  SHIFT_WIDTH  per-beat minimum, real lanes
- min_im_in  in  SHIFT_WIDTH  per-beat minimum, imag lanes
- wr_en  out  1  buffer write strobe (din_valid & din_ready)
- wr_bank  out  1  bank being written
- wr_addr  out  ADDR_WIDTH  beat address within bank
- dout_ready  in  1  downstream permits issuing a read this cycle
- rd_en  out  1  buffer read strobe
- rd_bank  out  1  bank being read
- rd_addr  out  ADDR_WIDTH  beat address within bank
- shift_amt_re  out  SHIFT_WIDTH  group shift for real lanes, held during drain
- shift_amt_im  out  SHIFT_WIDTH  group shift for imag lanes
- valid_out  out  1  rd_en delayed one cycle; aligned with buffer read data
- frame_last  out  1  with valid_out: last beat of frame
- grp_exp_valid  out  1  one-cycle pulse: group exponent latched
- overflow_err  out  1  sticky: a beat arrived while din_ready=0

Behaviour:
- Reset (async, rstn=0):
  - All outputs 0, except din_ready=1 once rstn deasserts.
  - Both banks EMPTY.
  - wr_bank=rd_bank=0, all counters 0.
  - Running minima set to all-ones.
  - Reset mid-group discards the partial group and any pending drain.
- Per-bank state: EMPTY -> FILLING (first write) -> FULL (last write) -> DRAINING (first read) -> EMPTY (last read).
- Write side:
  - din_ready = 1 when the bank at wr_bank is EMPTY or FILLING.
  - Each accepted beat asserts wr_en and increments wr_addr.
  - Running min: run_re <= min(run_re, min_re_in); same for imag. On the first beat of a group the input value is taken directly.
  - On the beat where wr_addr = GROUP_BEATS-1:
    - The final minimum, including that beat, is stored in the bank's shift register.
    - The bank goes FULL, wr_bank toggles, wr_addr wraps to 0, running minima reload to all-ones.
    - grp_exp_valid pulses the next cycle.
- Read side:
  - rd_en = dout_ready & bank at rd_bank in {FULL, DRAINING}.
  - rd_addr increments per rd_en.
  - shift_amt_re/im show the rd_bank shift register from the first read until the bank's last read. Otherwise they hold their last value.
  - On the read where rd_addr = GROUP_BEATS-1: bank goes EMPTY, rd_bank toggles, rd_addr wraps.
  - valid_out and frame_last are registered copies of rd_en and the last-read condition, delayed 1 cycle.
  - dout_ready is a credit: downstream accepts every beat whose read was issued.
- Frame counting: group counter on the read side, 0..FRAME_GROUPS-1. frame_last is set for the last beat of group FRAME_GROUPS-1.
- Latency:
  - First beat of a group at cycle t; group FULL after cycle t+GROUP_BEATS-1.
  - With dout_ready=1: rd_en at t+GROUP_BEATS, valid_out at t+GROUP_BEATS+1.
  - Continuous streaming with dout_ready=1 runs with zero bubbles, and din_ready stays 1.
- Simultaneous events:
  - A write completing bank X and a read completing bank Y in the same cycle both apply.
  - Reading X may start the very next cycle.
- Overflow: din_valid & !din_ready drops the beat, with no counter or minimum update, and sets overflow_err until reset.

Decomposition:
- Package cbfp_pkg: SHIFT_WIDTH constant, bank state enum {EMPTY, FILLING, FULL, DRAINING}, SHIFT_INIT all-ones constant.
- One natural sub-module: cbfp_run_min, a running-minimum register with load-first and clear controls, instantiated once each for real and imag.

Test Plan:
- Streaming: reset, 16 beats with din_valid=1, min_re_in=beat index+3, min_im_in=10, dout_ready=1.
  - Group 0: shift_amt_re=3, shift_amt_im=10.
  - Group 1: shift_amt_re=11.
  - First valid_out at cycle 9 after first beat; no bubbles; grp_exp_valid pulses twice.
- Min on last beat: 8 beats, min_re_in=20 except beat 7 = 2 -> shift_amt_re=2 for all 8 output beats.
- Backpressure: dout_ready=0 with 24 beats offered.
  - Banks 0 and 1 fill; din_ready drops after beat 16.
  - Beat 17 is dropped and overflow_err=1.
  - Raising dout_ready drains group 0 then group 1 with correct shifts.
- Frame marker: 32 continuous beats -> frame_last=1 only with the 32nd valid_out, then cycles again at beat 64.
- Reset mid-group: rstn=0 after 5 beats, then 8 fresh beats with min=7.
  - No valid_out from the partial group.
  - Next output group has shift 7; rd_bank=wr_bank=0 after reset.
- Simultaneous complete: stall dout_ready so that bank 1's last write coincides with bank 0's last read -> rd_en reads bank 1 the next cycle with bank 1's shift, with no lost beat.
